key_filter_multi: RTL and testbench

Parametrised multi-channel push-button conditioner for the DDS front panel. Per key it provides:
- input synchronisation;
- sampled debouncing with a configurable stability count;
- a debounced level, plus one-cycle press and release pulses;
- long-press detection with optional auto-repeat.

It sits between the board buttons and the DDS control logic (frequency/phase/waveform step controls). All channels share one sample-rate divider.

---
 rtl/key_filter_multi.sv | 183 ++++++++++++++++++
 tb/tb_key_filter_multi.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_filter_multi.sv
// Purpose : multi-channel push-button conditioner (sync, debounce, press/release, long-press, auto-repeat).
// Latency : 2 sync clocks + STABLE_CNT sample ticks to a debounced edge; every output is registered.
// Backpr. : none; free-running pulse outputs, downstream must accept one-clock pulses when they occur.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   key_in          raw asynchronous key pins (NUM_KEYS)
//   key_deb         debounced level, same polarity as key_in
//   key_press       one-clock pulse on debounced press
//   key_release     one-clock pulse on debounced release
//   key_long        one-clock pulse when the hold reaches LONG_TICKS ticks
//   key_rpt         one-clock auto-repeat pulses while held past the long press
//   sample_tick     one-clock pulse at each shared sample instant
// Optional feature: define KEY_FILTER_REPEAT_EN to build auto-repeat; otherwise key_rpt is tied to 0.

module key_filter_multi #(
  parameter int NUM_KEYS     = 4,
  parameter int CLK_DIV      = 999_999,
  parameter int STABLE_CNT   = 3,
  parameter int LONG_TICKS   = 50,
  parameter int REPEAT_TICKS = 10,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_deb,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_rpt,
  output logic                sample_tick
);

  localparam int DIV_W    = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [NUM_KEYS-1:0] IDLE_VEC = (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};
  localparam logic PRESS_LVL = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } hold_st_t;

  logic [DIV_W-1:0]    div_q, div_d;
  logic                tick_q, tick_d;
  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] deb_q, deb_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] long_q, long_d;
`ifdef KEY_FILTER_REPEAT_EN
  logic [NUM_KEYS-1:0] rpt_q, rpt_d;
`endif
  logic [3:0]          stab_q [NUM_KEYS];
  logic [3:0]          stab_d [NUM_KEYS];
  logic [HOLD_W-1:0]   hold_q [NUM_KEYS];
  logic [HOLD_W-1:0]   hold_d [NUM_KEYS];
  hold_st_t            st_q   [NUM_KEYS];
  hold_st_t            st_d   [NUM_KEYS];

  always_comb begin
    logic [HOLD_W-1:0] hold_inc;
    hold_inc  = '0;
    div_d     = (div_q == DIV_W'(CLK_DIV)) ? '0 : div_q + 1'b1;
    tick_d    = (div_q == DIV_W'(CLK_DIV));
    sync1_d   = key_in;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
`ifdef KEY_FILTER_REPEAT_EN
    rpt_d     = '0;
`endif
    for (int i = 0; i < NUM_KEYS; i++) begin
      stab_d[i] = stab_q[i];
      hold_d[i] = hold_q[i];
      st_d[i]   = st_q[i];
      if (tick_q) begin
        // Debounce: count consecutive samples that disagree with the debounced level.
        if (sync2_q[i] == deb_q[i]) begin
          stab_d[i] = '0;
        end else if (stab_q[i] == 4'(STABLE_CNT - 1)) begin
          stab_d[i] = '0;
          deb_d[i]  = ~deb_q[i];
          if (deb_q[i] == PRESS_LVL) release_d[i] = 1'b1;
          else                       press_d[i]   = 1'b1;
        end else begin
          stab_d[i] = stab_q[i] + 1'b1;
        end

        hold_inc = (hold_q[i] == HOLD_W'(HOLD_MAX)) ? hold_q[i] : hold_q[i] + 1'b1;
        // Release is checked first so it suppresses a long/repeat threshold on the same tick.
        if (release_d[i]) begin
          st_d[i]   = ST_IDLE;
          hold_d[i] = '0;
        end else if (press_d[i]) begin
          st_d[i]   = ST_HELD;
          hold_d[i] = '0;
        end else begin
          case (st_q[i])
            ST_HELD: begin
              if (hold_inc == HOLD_W'(LONG_TICKS)) begin
                long_d[i] = 1'b1;
                st_d[i]   = ST_LONG;
                hold_d[i] = '0;
              end else begin
                hold_d[i] = hold_inc;
              end
            end
            ST_LONG: begin
`ifdef KEY_FILTER_REPEAT_EN
              if (hold_inc == HOLD_W'(REPEAT_TICKS)) begin
                rpt_d[i]  = 1'b1;
                hold_d[i] = '0;
              end else begin
                hold_d[i] = hold_inc;
              end
`else
              hold_d[i] = hold_inc;
`endif
            end
            default: hold_d[i] = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      tick_q    <= 1'b0;
      sync1_q   <= IDLE_VEC;
      sync2_q   <= IDLE_VEC;
      deb_q     <= IDLE_VEC;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
`ifdef KEY_FILTER_REPEAT_EN
      rpt_q     <= '0;
`endif
      for (int i = 0; i < NUM_KEYS; i++) begin
        stab_q[i] <= '0;
        hold_q[i] <= '0;
        st_q[i]   <= ST_IDLE;
      end
    end else begin
      div_q     <= div_d;
      tick_q    <= tick_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
`ifdef KEY_FILTER_REPEAT_EN
      rpt_q     <= rpt_d;
`endif
      for (int i = 0; i < NUM_KEYS; i++) begin
        stab_q[i] <= stab_d[i];
        hold_q[i] <= hold_d[i];
        st_q[i]   <= st_d[i];
      end
    end
  end

  assign key_deb     = deb_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign sample_tick = tick_q;
`ifdef KEY_FILTER_REPEAT_EN
  assign key_rpt     = rpt_q;
`else
  assign key_rpt     = '0;
`endif

endmodule

// File: tb/tb_key_filter_multi.sv
// Purpose : self-checking bench for key_filter_multi (2 keys, divide-by-4 tick, 3-sample debounce).
// Latency : reference model is updated on every clock edge and compared at the following falling edge.
// Backpr. : not applicable; stimulus is free-running.

module tb_key_filter_multi;

  localparam int NK   = 2;
  localparam int DIV  = 3;
  localparam int STAB = 3;
  localparam int LONG = 5;
  localparam int REP  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_in = 2'b11;
  logic [NK-1:0] key_deb, key_press, key_release, key_long, key_rpt;
  logic          sample_tick;

  int checks   = 0;
  int failures = 0;

  key_filter_multi #(
    .NUM_KEYS(NK), .CLK_DIV(DIV), .STABLE_CNT(STAB),
    .LONG_TICKS(LONG), .REPEAT_TICKS(REP), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_deb(key_deb), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_rpt(key_rpt), .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  logic [10:0] dut_vec;
  assign dut_vec = {sample_tick, key_deb, key_press, key_release, key_long, key_rpt};

  // Reference model: edges since reset, a two-deep input delay, and per key the
  // length of the current run of disagreeing samples and the ticks held since press.
  int          n_edges;
  logic [1:0]  m_s1, m_s2, m_deb, m_press, m_rel, m_long, m_rpt;
  logic        m_tick;
  int          run_len [NK];
  int          held    [NK];
  bit          pressed [NK];
  logic [10:0] m_vec;

  task automatic model_edge();
    logic       tick_now;
    logic [1:0] smp;
    tick_now = m_tick;
    smp      = m_s2;
    m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0;
    if (rst) begin
      n_edges = 0; m_s1 = 2'b11; m_s2 = 2'b11; m_deb = 2'b11; m_tick = 1'b0;
      for (int k = 0; k < NK; k++) begin run_len[k] = 0; held[k] = 0; pressed[k] = 0; end
    end else begin
      if (tick_now) begin
        for (int k = 0; k < NK; k++) begin
          run_len[k] = (smp[k] != m_deb[k]) ? run_len[k] + 1 : 0;
          if (run_len[k] == STAB) begin
            run_len[k] = 0;
            m_deb[k]   = ~m_deb[k];
            if (m_deb[k] == 1'b0) begin m_press[k] = 1'b1; pressed[k] = 1; held[k] = 0; end
            else                  begin m_rel[k]   = 1'b1; pressed[k] = 0; end
          end else if (pressed[k]) begin
            held[k]++;
            if (held[k] == LONG) m_long[k] = 1'b1;
`ifdef KEY_FILTER_REPEAT_EN
            else if (held[k] > LONG && (held[k] - LONG) % REP == 0) m_rpt[k] = 1'b1;
`endif
          end
        end
      end
      n_edges++;
      m_tick = (n_edges % (DIV + 1) == 0);
      m_s2 = m_s1;
      m_s1 = key_in;
    end
    m_vec = {m_tick, m_deb, m_press, m_rel, m_long, m_rpt};
  endtask

  task automatic step(input logic [1:0] k);
    key_in = k;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int first_tick = -1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(2'b00);
      checks++;
      if (dut_vec !== 11'b0_11_00_00_00_00) begin
        failures++; $display("FAIL reset_state got=%b exp=%b", dut_vec, 11'b0_11_00_00_00_00);
      end
    end
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step(2'b00);
      if (sample_tick && first_tick < 0) first_tick = c;
      checks++;
      if (dut_vec !== m_vec) begin failures++; $display("FAIL reset_exit c=%0d got=%b exp=%b", c, dut_vec, m_vec); end
    end
    checks++;
    if (first_tick !== 4) begin failures++; $display("FAIL first_tick got=%0d exp=4", first_tick); end
    for (int c = 0; c < 24; c++) begin
      step(2'b11);
      checks++;
      if (dut_vec !== m_vec) begin failures++; $display("FAIL reset_settle c=%0d got=%b exp=%b", c, dut_vec, m_vec); end
    end
  endtask

  task automatic test_bounce();
    int np = 0;
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < 4; c++) begin
        step((b < 2) ? 2'b10 : 2'b11);
        if (key_press[0]) np++;
        checks++;
        if (dut_vec !== m_vec) begin failures++; $display("FAIL bounce b=%0d got=%b exp=%b", b, dut_vec, m_vec); end
      end
    end
    checks++;
    if (np !== 0) begin failures++; $display("FAIL bounce_press got=%0d exp=0", np); end
    checks++;
    if (key_deb[0] !== 1'b1) begin failures++; $display("FAIL bounce_deb got=%b exp=1", key_deb[0]); end
  endtask

  task automatic test_press();
    int np = 0, nr = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        step((b < 5) ? 2'b10 : 2'b11);
        if (key_press[0]) np++;
        if (key_release[0]) nr++;
        checks++;
        if (dut_vec !== m_vec) begin failures++; $display("FAIL press b=%0d got=%b exp=%b", b, dut_vec, m_vec); end
      end
      if (b == 4) begin
        checks++;
        if (key_deb[0] !== 1'b0) begin failures++; $display("FAIL press_deb got=%b exp=0", key_deb[0]); end
      end
    end
    checks++;
    if (np !== 1) begin failures++; $display("FAIL press_pulses got=%0d exp=1", np); end
    checks++;
    if (nr !== 1) begin failures++; $display("FAIL release_pulses got=%0d exp=1", nr); end
    checks++;
    if (key_deb[0] !== 1'b1) begin failures++; $display("FAIL release_deb got=%b exp=1", key_deb[0]); end
  endtask

  task automatic test_long_repeat();
    int nl = 0, nrp = 0, nr = 0, ticks = 0, t_press = -1, t_long = -1;
`ifdef KEY_FILTER_REPEAT_EN
    int exp_rpt = 4;
`else
    int exp_rpt = 0;
`endif
    for (int b = 0; b < 20; b++) begin
      for (int c = 0; c < 4; c++) begin
        step((b < 14) ? 2'b01 : 2'b11);
        if (sample_tick) ticks++;
        if (key_press[1]) t_press = ticks;
        if (key_long[1]) begin nl++; t_long = ticks; end
        if (key_rpt[1]) nrp++;
        if (key_release[1]) nr++;
        checks++;
        if (dut_vec !== m_vec) begin failures++; $display("FAIL long b=%0d got=%b exp=%b", b, dut_vec, m_vec); end
      end
    end
    checks++;
    if (nl !== 1) begin failures++; $display("FAIL long_pulses got=%0d exp=1", nl); end
    checks++;
    if (t_long - t_press !== LONG) begin failures++; $display("FAIL long_delay got=%0d exp=%0d", t_long - t_press, LONG); end
    checks++;
    if (nrp !== exp_rpt) begin failures++; $display("FAIL rpt_pulses got=%0d exp=%0d", nrp, exp_rpt); end
    checks++;
    if (nr !== 1) begin failures++; $display("FAIL long_release got=%0d exp=1", nr); end
  endtask

  task automatic test_release_at_threshold();
    int nl = 0, nr = 0, np = 0;
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < 4; c++) begin
        step((b < 5) ? 2'b01 : 2'b11);
        if (key_long[1]) nl++;
        if (key_release[1]) nr++;
        if (key_press[1]) np++;
        checks++;
        if (dut_vec !== m_vec) begin failures++; $display("FAIL thresh b=%0d got=%b exp=%b", b, dut_vec, m_vec); end
      end
    end
    checks++;
    if (np !== 1) begin failures++; $display("FAIL thresh_press got=%0d exp=1", np); end
    checks++;
    if (nl !== 0) begin failures++; $display("FAIL thresh_long got=%0d exp=0", nl); end
    checks++;
    if (nr !== 1) begin failures++; $display("FAIL thresh_release got=%0d exp=1", nr); end
  endtask

  task automatic test_reset_mid_hold();
    int nl = 0, nr = 0, np = 0;
    for (int c = 0; c < 36; c++) begin
      step(2'b10);
      if (key_long[0]) nl++;
      checks++;
      if (dut_vec !== m_vec) begin failures++; $display("FAIL midhold c=%0d got=%b exp=%b", c, dut_vec, m_vec); end
    end
    checks++;
    if (nl !== 1) begin failures++; $display("FAIL midhold_long got=%0d exp=1", nl); end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(2'b10);
      checks++;
      if (dut_vec !== 11'b0_11_00_00_00_00) begin
        failures++; $display("FAIL midhold_reset got=%b exp=%b", dut_vec, 11'b0_11_00_00_00_00);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(2'b10);
      if (key_release[0]) nr++;
      if (key_press[0]) np++;
      checks++;
      if (dut_vec !== m_vec) begin failures++; $display("FAIL midhold_redetect c=%0d got=%b exp=%b", c, dut_vec, m_vec); end
    end
    checks++;
    if (nr !== 0) begin failures++; $display("FAIL midhold_release got=%0d exp=0", nr); end
    checks++;
    if (np !== 1) begin failures++; $display("FAIL midhold_repress got=%0d exp=1", np); end
    for (int c = 0; c < 24; c++) begin
      step(2'b11);
      checks++;
      if (dut_vec !== m_vec) begin failures++; $display("FAIL midhold_tail c=%0d got=%b exp=%b", c, dut_vec, m_vec); end
    end
  endtask

  task automatic test_random();
    logic [1:0] k = 2'b11;
    int errs = 0;
    for (int c = 0; c < 1200; c++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 29) == 0) k[i] = ~k[i];
      step(k);
      checks++;
      if (dut_vec !== m_vec) begin
        failures++;
        if (errs < 10) $display("FAIL random c=%0d got=%b exp=%b", c, dut_vec, m_vec);
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_press();
    test_long_repeat();
    test_release_at_threshold();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
